// File: rtl/pwm_update_ctrl_pkg.sv
// pwm_update_ctrl_pkg: shared widths and enums for the PWM run/stop and update controller
// Mask encoding: bit 0 suppresses min strobes, bit 1 suppresses max strobes.
package pwm_update_ctrl_pkg;
    localparam int PWM_N_CARR         = 8;
    localparam int PWM_EVTCOUNT_WIDTH = 3;
    typedef enum logic [1:0] {NO_MASK = 2'd0, MIN_MASK = 2'd1, MAX_MASK = 2'd2, MINMAX_MASK = 2'd3} _mask_mode;
    typedef enum logic {PWM_OFF = 1'b0, PWM_ON = 1'b1} _pwm_onoff;
    typedef enum logic {INT_OFF = 1'b0, INT_ON = 1'b1} _int_onoff;
    typedef enum logic {CARR_OFF = 1'b0, CARR_ON = 1'b1} _carr_onoff;
    typedef enum logic [1:0] {CTRL_IDLE = 2'd0, CTRL_START = 2'd1, CTRL_RUN = 2'd2, CTRL_STOP = 2'd3} _ctrl_state;
endpackage

// File: rtl/pwm_update_ctrl_evt_prescaler.sv
// pwm_evt_prescaler: counts qualified events and flags the terminal one
// Ports: clk, rst_n (async, active-low); clr_i zeroes the count; evt_i qualified event;
//        prescale_i events per terminal minus 1; cnt_o current count; term_o terminal strobe (combinational).
module pwm_evt_prescaler
    import pwm_update_ctrl_pkg::*;
#(
    parameter int W = PWM_EVTCOUNT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         evt_i,
    input  logic [W-1:0] prescale_i,
    output logic [W-1:0] cnt_o,
    output logic         term_o
);
    logic [W-1:0] cnt_q, cnt_d;
    // >= lets a lowered prescale fire on the next event and keeps the count from wrapping
    assign term_o = evt_i && cnt_q >= prescale_i;
    assign cnt_o  = cnt_q;
    always_comb cnt_d = (clr_i || term_o) ? '0 : evt_i ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/pwm_update_ctrl.sv
// pwm_update_ctrl: carrier run/stop sequencer and shadow-register load scheduler
// Ports: clk, rst_n (async, active-low); pwm_onoff_i run request; mask_mode_i event mask;
//        int_onoff_i irq enable; evt_prescale_i events per terminal minus 1; carr_en_i carrier enables;
//        upd_req_i commit request; carr_min_i/carr_max_i master carrier strobes;
//        carr_onoff_o carrier run enables; carr_rst_o counter clear; load_o shadow load;
//        irq_o interrupt; upd_busy_o request pending; evt_cnt_o prescaler count.
module pwm_update_ctrl
    import pwm_update_ctrl_pkg::*;
#(
    parameter int N_CARR         = PWM_N_CARR,
    parameter int EVTCOUNT_WIDTH = PWM_EVTCOUNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pwm_onoff_i,
    input  logic [1:0]                mask_mode_i,
    input  logic                      int_onoff_i,
    input  logic [EVTCOUNT_WIDTH-1:0] evt_prescale_i,
    input  logic [N_CARR-1:0]         carr_en_i,
    input  logic                      upd_req_i,
    input  logic                      carr_min_i,
    input  logic                      carr_max_i,
    output logic [N_CARR-1:0]         carr_onoff_o,
    output logic                      carr_rst_o,
    output logic                      load_o,
    output logic                      irq_o,
    output logic                      upd_busy_o,
    output logic [EVTCOUNT_WIDTH-1:0] evt_cnt_o
);
    logic [1:0]        state_q, state_d;
    logic [N_CARR-1:0] on_q, on_d;
    logic              crst_q, crst_d, load_q, load_d, irq_q, irq_d, pend_q, pend_d;
    logic              run, qual, term, clr;
    assign run  = state_q == CTRL_RUN;
    assign qual = (carr_min_i && !mask_mode_i[0]) || (carr_max_i && !mask_mode_i[1]);
    // the stop boundary uses the raw min strobe, independent of the event mask
    assign clr  = state_q == CTRL_START || (state_q == CTRL_STOP && carr_min_i);
    pwm_evt_prescaler #(.W(EVTCOUNT_WIDTH)) u_presc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr),
        .evt_i     (qual && run),
        .prescale_i(evt_prescale_i),
        .cnt_o     (evt_cnt_o),
        .term_o    (term)
    );
    always_comb begin
        state_d = state_q;
        on_d    = on_q;
        crst_d  = 1'b0;
        load_d  = 1'b0;
        irq_d   = 1'b0;
        // a new request always survives a same-cycle clear
        pend_d  = upd_req_i || (pend_q && !term && state_q != CTRL_START);
        case (state_q)
            CTRL_IDLE:
                if (pwm_onoff_i == PWM_ON) begin
                    state_d = CTRL_START;
                    crst_d  = 1'b1;
                    load_d  = 1'b1;
                end
            CTRL_START: begin
                state_d = CTRL_RUN;
                on_d    = carr_en_i;
            end
            CTRL_RUN: begin
                load_d  = term && pend_q;
                irq_d   = term && int_onoff_i == INT_ON;
                on_d    = (term && pend_q) ? carr_en_i : on_q;
                state_d = pwm_onoff_i == PWM_OFF ? CTRL_STOP : CTRL_RUN;
            end
            default: begin
                state_d = carr_min_i ? CTRL_IDLE : pwm_onoff_i == PWM_ON ? CTRL_RUN : CTRL_STOP;
                on_d    = carr_min_i ? '0 : on_q;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= CTRL_IDLE;
            on_q    <= '0;
            crst_q  <= 1'b0;
            load_q  <= 1'b0;
            irq_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            on_q    <= on_d;
            crst_q  <= crst_d;
            load_q  <= load_d;
            irq_q   <= irq_d;
            pend_q  <= pend_d;
        end
    assign carr_onoff_o = on_q;
    assign carr_rst_o   = crst_q;
    assign load_o       = load_q;
    assign irq_o        = irq_q;
    assign upd_busy_o   = pend_q;
endmodule

// File: tb/tb_pwm_update_ctrl.sv
// tb_pwm_update_ctrl: table vectors, directed stop/reset sequences and a randomized model check
module tb_pwm_update_ctrl;
    import pwm_update_ctrl_pkg::*;
    logic       clk = 0, rst_n = 1, pwm_on = 0, int_on = 0, req = 0, cmin = 0, cmax = 0;
    logic [1:0] mask = 0;
    logic [2:0] presc = 0;
    logic [7:0] en = 0;
    logic [7:0] on_o;
    logic       crst, load, irq, busy;
    logic [2:0] cnt;
    int checks = 0, errors = 0;

    typedef struct {
        logic cmin, cmax; logic [1:0] mask; logic [2:0] presc; logic req, int_on; logic [7:0] en;
        logic [2:0] cnt; logic irq, load, busy; logic [7:0] on;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    pwm_update_ctrl dut (
        .clk(clk), .rst_n(rst_n), .pwm_onoff_i(pwm_on), .mask_mode_i(mask), .int_onoff_i(int_on),
        .evt_prescale_i(presc), .carr_en_i(en), .upd_req_i(req), .carr_min_i(cmin), .carr_max_i(cmax),
        .carr_onoff_o(on_o), .carr_rst_o(crst), .load_o(load), .irq_o(irq), .upd_busy_o(busy), .evt_cnt_o(cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(input logic mn, mx, input logic [1:0] mk, input logic [2:0] ps, input logic rq, it,
                               input logic [7:0] e, input logic [2:0] c, input logic iq, ld, bs, input logic [7:0] o);
        vec_t r;
        r.cmin = mn; r.cmax = mx; r.mask = mk; r.presc = ps; r.req = rq; r.int_on = it; r.en = e;
        r.cnt = c; r.irq = iq; r.load = ld; r.busy = bs; r.on = o;
        return r;
    endfunction

    int   m_cnt;
    bit   m_pend, ev, term, e_load, e_irq;
    logic [7:0] m_on;

    initial begin
        #2 rst_n = 0;
        #1;
        chk("rst_on", on_o, 0); chk("rst_crst", crst, 0); chk("rst_load", load, 0);
        chk("rst_irq", irq, 0); chk("rst_busy", busy, 0); chk("rst_cnt", cnt, 0);
        tick; tick;
        rst_n = 1;
        pwm_on = 1; en = 8'hA5; int_on = 1; mask = NO_MASK; presc = 2;
        tick;
        chk("start_crst", crst, 1); chk("start_load", load, 1); chk("start_on", on_o, 0);
        tick;
        chk("run_crst", crst, 0); chk("run_load", load, 0); chk("run_on", on_o, 8'hA5);

        tbl.push_back(v(1,0,NO_MASK,2,0,1,8'hA5, 1,0,0,0,8'hA5));
        tbl.push_back(v(0,1,NO_MASK,2,0,1,8'hA5, 2,0,0,0,8'hA5));
        tbl.push_back(v(1,0,NO_MASK,2,0,1,8'hA5, 0,1,0,0,8'hA5));
        tbl.push_back(v(0,0,NO_MASK,2,0,1,8'hA5, 0,0,0,0,8'hA5));
        tbl.push_back(v(0,1,NO_MASK,2,0,1,8'hA5, 1,0,0,0,8'hA5));
        tbl.push_back(v(1,1,NO_MASK,2,0,1,8'hA5, 2,0,0,0,8'hA5));
        tbl.push_back(v(0,1,NO_MASK,2,0,1,8'hA5, 0,1,0,0,8'hA5));
        tbl.push_back(v(0,1,NO_MASK,3,0,1,8'hA5, 1,0,0,0,8'hA5));
        tbl.push_back(v(0,1,NO_MASK,3,0,1,8'hA5, 2,0,0,0,8'hA5));
        tbl.push_back(v(0,1,NO_MASK,1,0,1,8'hA5, 0,1,0,0,8'hA5));
        tbl.push_back(v(0,0,MAX_MASK,0,1,1,8'hA5, 0,0,0,1,8'hA5));
        tbl.push_back(v(0,1,MAX_MASK,0,0,1,8'h5A, 0,0,0,1,8'hA5));
        tbl.push_back(v(0,1,MAX_MASK,0,0,1,8'h5A, 0,0,0,1,8'hA5));
        tbl.push_back(v(1,0,MAX_MASK,0,0,1,8'h5A, 0,1,1,0,8'h5A));
        tbl.push_back(v(0,0,MAX_MASK,0,1,1,8'h3C, 0,0,0,1,8'h5A));
        tbl.push_back(v(1,0,MAX_MASK,0,1,1,8'h3C, 0,1,1,1,8'h3C));
        tbl.push_back(v(1,0,MAX_MASK,0,0,1,8'hC3, 0,1,1,0,8'hC3));
        tbl.push_back(v(1,0,MAX_MASK,0,0,0,8'hC3, 0,0,0,0,8'hC3));
        tbl.push_back(v(1,1,MINMAX_MASK,0,0,1,8'hC3, 0,0,0,0,8'hC3));
        tbl.push_back(v(1,0,MIN_MASK,1,0,1,8'hC3, 0,0,0,0,8'hC3));
        tbl.push_back(v(0,1,MIN_MASK,1,0,1,8'hC3, 1,0,0,0,8'hC3));
        tbl.push_back(v(0,1,MIN_MASK,1,0,1,8'hC3, 0,1,0,0,8'hC3));
        foreach (tbl[i]) begin
            cmin = tbl[i].cmin; cmax = tbl[i].cmax; mask = tbl[i].mask; presc = tbl[i].presc;
            req = tbl[i].req; int_on = tbl[i].int_on; en = tbl[i].en;
            tick;
            chk($sformatf("v%0d_cnt", i), cnt, tbl[i].cnt);
            chk($sformatf("v%0d_irq", i), irq, tbl[i].irq);
            chk($sformatf("v%0d_load", i), load, tbl[i].load);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("v%0d_on", i), on_o, tbl[i].on);
            chk($sformatf("v%0d_crst", i), crst, 0);
        end
        cmin = 0; cmax = 0; req = 0; int_on = 1;

        // terminal event with pending in the same cycle PWM_OFF arrives, then stop on min
        mask = NO_MASK; presc = 0; req = 1;
        tick;
        chk("so_busy", busy, 1);
        req = 0; cmin = 1; pwm_on = 0; en = 8'h77;
        tick;
        chk("so_load", load, 1); chk("so_irq", irq, 1); chk("so_busy0", busy, 0); chk("so_on", on_o, 8'h77);
        cmin = 0;
        tick;
        chk("stop_on0", on_o, 8'h77);
        cmax = 1;
        tick;
        chk("stop_on1", on_o, 8'h77);
        tick;
        chk("stop_on2", on_o, 8'h77);
        cmax = 0; cmin = 1;
        tick;
        chk("stop_off", on_o, 0);
        cmin = 0;
        tick;
        chk("idle_off", on_o, 0); chk("idle_crst", crst, 0);

        // restart, then abort a stop by reasserting PWM_ON
        en = 8'h0F; pwm_on = 1; presc = 7;
        tick;
        chk("rs_crst", crst, 1); chk("rs_load", load, 1);
        tick;
        chk("rs_on", on_o, 8'h0F);
        mask = MAX_MASK; pwm_on = 0;
        tick;
        cmax = 1;
        tick;
        tick;
        chk("ab_stay", on_o, 8'h0F);
        cmax = 0; pwm_on = 1;
        tick;
        chk("ab_crst", crst, 0); chk("ab_on", on_o, 8'h0F);
        tick;
        chk("ab_crst2", crst, 0); chk("ab_load", load, 0);
        mask = NO_MASK; cmin = 1;
        tick;
        chk("ab_cnt", cnt, 1);
        cmin = 0; pwm_on = 0;
        tick;
        cmin = 1;
        tick;
        cmin = 0; en = 8'h96; pwm_on = 1;
        tick;
        tick;
        chk("rnd_start_on", on_o, 8'h96);

        m_cnt = 0; m_pend = 0; m_on = 8'h96;
        for (int i = 0; i < 400; i++) begin
            cmin = ($urandom_range(0, 2) == 0);
            cmax = ($urandom_range(0, 2) == 0);
            mask = 2'($urandom_range(0, 3));
            presc = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
            req = ($urandom_range(0, 7) == 0);
            int_on = ($urandom_range(0, 3) != 0);
            en = 8'($urandom);
            ev = (cmin && !(mask == MIN_MASK || mask == MINMAX_MASK)) ||
                 (cmax && !(mask == MAX_MASK || mask == MINMAX_MASK));
            term = ev && m_cnt >= int'(presc);
            e_load = term && m_pend;
            e_irq = term && int_on;
            if (term) begin
                m_cnt = 0;
                if (m_pend) m_on = en;
            end else if (ev) m_cnt++;
            m_pend = req || (m_pend && !term);
            tick;
            chk($sformatf("r%0d_cnt", i), cnt, m_cnt);
            chk($sformatf("r%0d_load", i), load, e_load);
            chk($sformatf("r%0d_irq", i), irq, e_irq);
            chk($sformatf("r%0d_busy", i), busy, m_pend);
            chk($sformatf("r%0d_on", i), on_o, m_on);
            chk($sformatf("r%0d_crst", i), crst, 0);
        end
        cmin = 0; cmax = 0;

        // asynchronous reset mid-run with a request pending
        req = 1;
        tick;
        req = 0;
        chk("ar_busy", busy, 1);
        #2 rst_n = 0;
        #1;
        chk("ar_on", on_o, 0); chk("ar_busy0", busy, 0); chk("ar_crst", crst, 0);
        chk("ar_load", load, 0); chk("ar_irq", irq, 0); chk("ar_cnt", cnt, 0);
        pwm_on = 0;
        #3 rst_n = 1;
        tick;
        chk("ar_idle_on", on_o, 0); chk("ar_idle_busy", busy, 0);
        pwm_on = 1;
        tick;
        chk("ar_restart", crst, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_update_ctrl.md
# pwm_update_ctrl

Run/stop sequencer and shadow-register update scheduler for the 8-carrier PWM block. It starts carriers synchronously and qualifies master-carrier count events through the mask mode and an event prescaler. On terminal events it issues the shadow→active load pulse and the interrupt. It stops carriers only at a counter-minimum boundary. It sits between the register interface and the carrier/dead-time datapath; its enums come from PKG_pwm.

## Interface
- N_CARR, 8, number of controlled carriers
- EVTCOUNT_WIDTH, `EVTCOUNT_WIDTH (3), event prescaler width

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pwm_onoff_i  in  _pwm_onoff  global run request (level)
- mask_mode_i  in  _mask_mode  carrier events suppressed from qualification
- int_onoff_i  in  _int_onoff  interrupt enable
- evt_prescale_i  in  EVTCOUNT_WIDTH  qualified events per terminal event, minus 1
- carr_en_i  in  N_CARR  per-carrier enable, captured at start and at each load
- upd_req_i  in  1  one-cycle request to commit shadow registers
- carr_min_i  in  1  master carrier (carrier 0) at count minimum, one-cycle strobe
- carr_max_i  in  1  master carrier at count maximum, one-cycle strobe
- carr_onoff_o  out  N_CARR  per-carrier run enable (_carr_onoff per bit)
- carr_rst_o  out  1  one-cycle synchronous clear of all carrier counters
- load_o  out  1  one-cycle shadow→active load strobe
- irq_o  out  1  one-cycle interrupt pulse
- upd_busy_o  out  1  update request pending
- evt_cnt_o  out  EVTCOUNT_WIDTH  current prescaler count

## Operation
- Reset values: state IDLE, all outputs 0, prescaler count 0, pending flag 0.
- Qualified event is the OR of the unmasked strobes. NO_MASK: min or max. MIN_MASK: max only. MAX_MASK: min only. MINMAX_MASK: none. Simultaneous min and max count as one event.
- States:
  - IDLE: carr_onoff_o = 0. Moves to START when pwm_onoff_i == PWM_ON.
  - START, one cycle: carr_rst_o = 1 and load_o = 1; captures carr_en_i; clears prescaler and pending; moves to RUN.
  - RUN: carr_onoff_o = captured enables. A qualified event with evt_cnt >= evt_prescale_i is terminal; otherwise it increments evt_cnt. A terminal event sets evt_cnt = 0. If pending, it pulses load_o, recaptures carr_en_i and clears pending. If int_onoff_i == INT_ON, it pulses irq_o. pwm_onoff_i == PWM_OFF moves to STOP.
  - STOP: carriers stay on. carr_min_i (unmasked) sets carr_onoff_o = 0, evt_cnt = 0, and moves to IDLE. pwm_onoff_i back to PWM_ON before that returns to RUN with no restart.
- Pending: set by upd_req_i in any state. A set in the same cycle as a clear wins, so that request waits for the next terminal event. upd_busy_o equals pending.
- Prescaler uses >= so lowering evt_prescale_i mid-run fires on the next qualified event. No wrap.
- Stop order: load and irq on the same terminal event are still issued if STOP is entered that cycle.

## Timing
- All outputs registered. An event or request in cycle t produces the response in cycle t+1.
- PWM_ON in IDLE at cycle t: carr_rst_o and load_o in t+1; carr_onoff_o high from t+2.
- Terminal event at t: load_o, irq_o and evt_cnt_o = 0 at t+1. upd_busy_o low at t+1.
- carr_min_i in STOP at t: carr_onoff_o = 0 at t+1.
- Asynchronous reset drops all outputs immediately, mid-operation included. After rst_n deasserts, operation resumes from IDLE on the first clock edge.

## Structure
- PKG_pwm gains _ctrl_state enum {CTRL_IDLE, CTRL_START, CTRL_RUN, CTRL_STOP} (logic [1:0]); reuses _mask_mode, _pwm_onoff, _int_onoff, _carr_onoff.
- One sub-module, pwm_evt_prescaler: qualified-event input, prescale input, clear; outputs count and terminal strobe.

## Test plan
- Reset, then PWM_ON, carr_en_i = 8'hA5 -> carr_rst_o and load_o at +1; carr_onoff_o = 8'hA5 at +2.
- NO_MASK, prescale 2, alternating min/max strobes -> evt_cnt_o 1, 2, 0; irq_o on every 3rd event; no load_o without upd_req_i.
- MAX_MASK, upd_req_i pulse, then max strobes, then a min strobe -> upd_busy_o stays 1 through the max strobes; load_o on the min strobe, updating carr_onoff_o to the new carr_en_i in the same cycle.
- upd_req_i in the same cycle as a terminal event with pending = 1 -> load_o at +1 and upd_busy_o remains 1 for the next terminal event.
- PWM_OFF, two max strobes, then a min strobe -> carriers stay on through the max strobes, carr_onoff_o = 0 the cycle after min. Repeat with PWM_ON reasserted before min -> returns to RUN, no carr_rst_o.
- rst_n low during RUN with pending = 1 -> all outputs 0 immediately; after release, IDLE and upd_busy_o = 0.
